// File: rtl/matmul_pool_engine.sv
// matmul_pool_engine: loads NxN byte matrices A and B, computes C = A*B,
// applies PxP max/average pooling with 8-bit saturation and writes packed bytes.
module matmul_pool_engine #(
    parameter int unsigned N      = 4,
    parameter int unsigned P      = 2,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned BASE_A = 'h000,
    parameter int unsigned BASE_B = 'h100,
    parameter int unsigned BASE_C = 'h200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              kick_start,
    input  logic              pool_mode,
    output logic              ready,
    output logic              done,
    output logic              mem_en_read_A,
    output logic [ADDR_W-1:0] mem_addr_A,
    input  logic [31:0]       mem_data_A,
    output logic              mem_en_read_B,
    output logic [ADDR_W-1:0] mem_addr_B,
    input  logic [31:0]       mem_data_B,
    output logic              mem_en_write_C,
    output logic [ADDR_W-1:0] mem_addr_C,
    output logic [31:0]       mem_data_C
);
    localparam int unsigned NE = N * N;
    localparam int unsigned W  = NE / 4;
    localparam int unsigned NP = N / P;
    localparam int unsigned IW = $clog2(N);
    localparam int unsigned EW = $clog2(NE);
    localparam int unsigned CW = $clog2(W + 2);
    localparam int unsigned AW = 16 + $clog2(N);
    localparam int unsigned LP = $clog2(P);
    localparam int unsigned SW = AW + 2 * LP;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_POOL, S_WBACK, S_DONE} state_t;

    state_t              state_q, state_d;
    logic                mode_q, mode_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       mi_q, mi_d, mj_q, mj_d, mk_q, mk_d;
    logic [IW-1:0]       pr_q, pr_d, pc_q, pc_d, wr_q, wr_d, wc_q, wc_d;
    logic [AW-1:0]       acc_q, acc_d;
    logic [SW-1:0]       pacc_q, pacc_d;
    logic [31:0]         pack_q, pack_d;
    logic [1:0]          bsel_q, bsel_d;
    logic [ADDR_W-1:0]   wptr_q, wptr_d;

    logic                ready_d, done_d, rd_en_d, wr_en_d;
    logic [ADDR_W-1:0]   rd_addr_a_d, rd_addr_b_d, wr_addr_d;
    logic [31:0]         wr_data_d;

    logic [7:0]          a_q [NE];
    logic [7:0]          b_q [NE];
    logic [AW-1:0]       c_q [NE];

    logic                ld_we, c_we, pfirst, last_out;
    logic [EW-1:0]       ld_base, a_idx, b_idx, c_idx, p_idx;
    logic [15:0]         prod;
    logic [AW-1:0]       msum;
    logic [IW-1:0]       prow, pcol;
    logic [SW-1:0]       pext, pnew, pres;
    logic [7:0]          pbyte;
    logic [31:0]         pack_word;

    // Next-state, datapath and registered-output values
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        mi_d        = mi_q;
        mj_d        = mj_q;
        mk_d        = mk_q;
        acc_d       = acc_q;
        pr_d        = pr_q;
        pc_d        = pc_q;
        wr_d        = wr_q;
        wc_d        = wc_q;
        pacc_d      = pacc_q;
        pack_d      = pack_q;
        bsel_d      = bsel_q;
        wptr_d      = wptr_q;
        rd_en_d     = 1'b0;
        rd_addr_a_d = '0;
        rd_addr_b_d = '0;
        wr_en_d     = 1'b0;
        wr_addr_d   = '0;
        wr_data_d   = '0;
        ld_we       = 1'b0;
        c_we        = 1'b0;

        ld_base   = EW'(cnt_q - CW'(2)) << 2;
        a_idx     = EW'(mi_q) * EW'(N) + EW'(mk_q);
        b_idx     = EW'(mk_q) * EW'(N) + EW'(mj_q);
        c_idx     = EW'(mi_q) * EW'(N) + EW'(mj_q);
        prod      = 16'(a_q[a_idx]) * 16'(b_q[b_idx]);
        msum      = acc_q + AW'(prod);

        prow      = (pr_q << LP) + wr_q;
        pcol      = (pc_q << LP) + wc_q;
        p_idx     = EW'(prow) * EW'(N) + EW'(pcol);
        pext      = SW'(c_q[p_idx]);
        pfirst    = (wr_q == '0) && (wc_q == '0);
        last_out  = (pr_q == IW'(NP - 1)) && (pc_q == IW'(NP - 1));
        if (pfirst)
            pnew = pext;
        else if (mode_q)
            pnew = pacc_q + pext;
        else
            pnew = (pext > pacc_q) ? pext : pacc_q;
        pres      = mode_q ? (pnew >> (2 * LP)) : pnew;
        pbyte     = (pres > SW'(255)) ? 8'hFF : pres[7:0];
        pack_word = pack_q;
        pack_word[{bsel_q, 3'b000} +: 8] = pbyte;

        case (state_q)
            S_IDLE: begin
                if (kick_start) begin
                    state_d = S_LOAD;
                    mode_d  = pool_mode;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                // Strobes for words 0..W-1; data lands two counts later, the last in the drain count
                cnt_d = cnt_q + CW'(1);
                if (cnt_q < CW'(W)) begin
                    rd_en_d     = 1'b1;
                    rd_addr_a_d = ADDR_W'(BASE_A) + ADDR_W'(cnt_q);
                    rd_addr_b_d = ADDR_W'(BASE_B) + ADDR_W'(cnt_q);
                end
                if (cnt_q >= CW'(2))
                    ld_we = 1'b1;
                if (cnt_q == CW'(W + 1)) begin
                    state_d = S_MAC;
                    mi_d    = '0;
                    mj_d    = '0;
                    mk_d    = '0;
                    acc_d   = '0;
                end
            end
            S_MAC: begin
                if (mk_q == IW'(N - 1)) begin
                    c_we  = 1'b1;
                    acc_d = '0;
                    mk_d  = '0;
                    if (mj_q == IW'(N - 1)) begin
                        mj_d = '0;
                        if (mi_q == IW'(N - 1)) begin
                            state_d = S_POOL;
                            pr_d    = '0;
                            pc_d    = '0;
                            wr_d    = '0;
                            wc_d    = '0;
                            pack_d  = '0;
                            bsel_d  = '0;
                            wptr_d  = '0;
                        end else begin
                            mi_d = mi_q + IW'(1);
                        end
                    end else begin
                        mj_d = mj_q + IW'(1);
                    end
                end else begin
                    acc_d = msum;
                    mk_d  = mk_q + IW'(1);
                end
            end
            S_POOL: begin
                pacc_d = pnew;
                if (wc_q == IW'(P - 1)) begin
                    wc_d = '0;
                    if (wr_q == IW'(P - 1)) begin
                        wr_d = '0;
                        if (bsel_q == 2'd3 || last_out) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = ADDR_W'(BASE_C) + wptr_q;
                            wr_data_d = pack_word;
                            pack_d    = '0;
                            bsel_d    = '0;
                            wptr_d    = wptr_q + ADDR_W'(1);
                        end else begin
                            pack_d = pack_word;
                            bsel_d = bsel_q + 2'd1;
                        end
                        if (last_out) begin
                            state_d = S_WBACK;
                        end else if (pc_q == IW'(NP - 1)) begin
                            pc_d = '0;
                            pr_d = pr_q + IW'(1);
                        end else begin
                            pc_d = pc_q + IW'(1);
                        end
                    end else begin
                        wr_d = wr_q + IW'(1);
                    end
                end else begin
                    wc_d = wc_q + IW'(1);
                end
            end
            S_WBACK: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    // State, control registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            mode_q         <= 1'b0;
            cnt_q          <= '0;
            mi_q           <= '0;
            mj_q           <= '0;
            mk_q           <= '0;
            acc_q          <= '0;
            pr_q           <= '0;
            pc_q           <= '0;
            wr_q           <= '0;
            wc_q           <= '0;
            pacc_q         <= '0;
            pack_q         <= '0;
            bsel_q         <= '0;
            wptr_q         <= '0;
            ready          <= 1'b1;
            done           <= 1'b0;
            mem_en_read_A  <= 1'b0;
            mem_addr_A     <= '0;
            mem_en_read_B  <= 1'b0;
            mem_addr_B     <= '0;
            mem_en_write_C <= 1'b0;
            mem_addr_C     <= '0;
            mem_data_C     <= '0;
        end else begin
            state_q        <= state_d;
            mode_q         <= mode_d;
            cnt_q          <= cnt_d;
            mi_q           <= mi_d;
            mj_q           <= mj_d;
            mk_q           <= mk_d;
            acc_q          <= acc_d;
            pr_q           <= pr_d;
            pc_q           <= pc_d;
            wr_q           <= wr_d;
            wc_q           <= wc_d;
            pacc_q         <= pacc_d;
            pack_q         <= pack_d;
            bsel_q         <= bsel_d;
            wptr_q         <= wptr_d;
            ready          <= ready_d;
            done           <= done_d;
            mem_en_read_A  <= rd_en_d;
            mem_addr_A     <= rd_addr_a_d;
            mem_en_read_B  <= rd_en_d;
            mem_addr_B     <= rd_addr_b_d;
            mem_en_write_C <= wr_en_d;
            mem_addr_C     <= wr_addr_d;
            mem_data_C     <= wr_data_d;
        end
    end

    // Matrix storage: operand capture during LOAD, product row-major during MAC
    always_ff @(posedge clk) begin
        if (ld_we) begin
            for (int k = 0; k < 4; k++) begin
                a_q[ld_base + EW'(k)] <= mem_data_A[8*k +: 8];
                b_q[ld_base + EW'(k)] <= mem_data_B[8*k +: 8];
            end
        end
        if (c_we)
            c_q[c_idx] <= msum;
    end

endmodule

// File: tb/tb_matmul_pool_engine.sv
// Directed bench for matmul_pool_engine: N=4 and N=8 instances with word memories.
module tb_matmul_pool_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        kick4 = 1'b0, mode4 = 1'b0, ready4, done4;
    logic        ra4, rb4, wc4;
    logic [9:0]  aa4, ab4, ac4;
    logic [31:0] da4 = '0, db4 = '0, dc4;

    logic        kick8 = 1'b0, mode8 = 1'b0, ready8, done8;
    logic        ra8, rb8, wc8;
    logic [9:0]  aa8, ab8, ac8;
    logic [31:0] da8 = '0, db8 = '0, dc8;

    logic [31:0] mem4 [1024];
    logic [31:0] mem8 [1024];
    int wcnt4 = 0, ovl4 = 0, wcnt8 = 0, ovl8 = 0;
    logic [9:0] lastaddr4 = '0;

    int n_checks = 0;
    int n_pass   = 0;

    matmul_pool_engine dut4 (
        .clk(clk), .rst(rst), .kick_start(kick4), .pool_mode(mode4),
        .ready(ready4), .done(done4),
        .mem_en_read_A(ra4), .mem_addr_A(aa4), .mem_data_A(da4),
        .mem_en_read_B(rb4), .mem_addr_B(ab4), .mem_data_B(db4),
        .mem_en_write_C(wc4), .mem_addr_C(ac4), .mem_data_C(dc4)
    );

    matmul_pool_engine #(.N(8), .P(2)) dut8 (
        .clk(clk), .rst(rst), .kick_start(kick8), .pool_mode(mode8),
        .ready(ready8), .done(done8),
        .mem_en_read_A(ra8), .mem_addr_A(aa8), .mem_data_A(da8),
        .mem_en_read_B(rb8), .mem_addr_B(ab8), .mem_data_B(db8),
        .mem_en_write_C(wc8), .mem_addr_C(ac8), .mem_data_C(dc8)
    );

    // Memory models: one-cycle read latency, write log, read/write overlap counter
    always @(posedge clk) begin
        if (ra4) da4 <= mem4[aa4];
        if (rb4) db4 <= mem4[ab4];
        if (wc4) begin
            mem4[ac4] = dc4;
            lastaddr4 = ac4;
            wcnt4 = wcnt4 + 1;
        end
        if ((ra4 || rb4) && wc4) ovl4 = ovl4 + 1;
        if (ra8) da8 <= mem8[aa8];
        if (rb8) db8 <= mem8[ab8];
        if (wc8) begin
            mem8[ac8] = dc8;
            wcnt8 = wcnt8 + 1;
        end
        if ((ra8 || rb8) && wc8) ovl8 = ovl8 + 1;
    end

    task automatic load_ident_ramp4();
        mem4[0] = 32'h00000001; mem4[1] = 32'h00000100;
        mem4[2] = 32'h00010000; mem4[3] = 32'h01000000;
        mem4[256] = 32'h04030201; mem4[257] = 32'h08070605;
        mem4[258] = 32'h0C0B0A09; mem4[259] = 32'h100F0E0D;
        mem4[512] = 32'hDEADBEEF;
        wcnt4 = 0;
        ovl4  = 0;
    endtask

    // Kick a job on the N=4 instance; flips pool_mode after acceptance; lat counts from the sampling edge
    task automatic run4(input logic mode, output int lat);
        @(negedge clk); kick4 = 1'b1; mode4 = mode;
        @(negedge clk); kick4 = 1'b0; mode4 = ~mode;
        lat = -1;
        for (int c = 1; c < 2000; c++) begin
            @(negedge clk);
            if (done4) begin lat = c; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (ready4 !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready4); else n_pass++;
        n_checks++; if (done4 !== 1'b0) $display("FAIL reset_done: got %b want 0", done4); else n_pass++;
        n_checks++; if ({ra4, rb4, wc4} !== 3'b000) $display("FAIL reset_strobes: got %b want 000", {ra4, rb4, wc4}); else n_pass++;
        n_checks++; if ({aa4, ab4, ac4} !== 30'd0) $display("FAIL reset_addrs: got %h want 0", {aa4, ab4, ac4}); else n_pass++;
        n_checks++; if (dc4 !== 32'd0) $display("FAIL reset_wdata: got %h want 0", dc4); else n_pass++;
        n_checks++; if ({ready8, done8, wc8} !== 3'b100) $display("FAIL reset_n8: got %b want 100", {ready8, done8, wc8}); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_max_mode();
        int lat;
        load_ident_ramp4();
        run4(1'b0, lat);
        n_checks++; if (lat != 87) $display("FAIL max_latency: got %0d want 87", lat); else n_pass++;
        n_checks++; if (mem4[512] !== 32'h100E0806) $display("FAIL max_word: got %h want 100e0806", mem4[512]); else n_pass++;
        n_checks++; if (wcnt4 != 1) $display("FAIL max_wcount: got %0d want 1", wcnt4); else n_pass++;
        n_checks++; if (lastaddr4 !== 10'h200) $display("FAIL max_waddr: got %h want 200", lastaddr4); else n_pass++;
        n_checks++; if (ovl4 != 0) $display("FAIL max_overlap: got %0d want 0", ovl4); else n_pass++;
        @(negedge clk);
        n_checks++; if (ready4 !== 1'b1 || done4 !== 1'b0) $display("FAIL max_post_done: got %b%b want 10", ready4, done4); else n_pass++;
    endtask

    task automatic test_avg_mode();
        int lat;
        load_ident_ramp4();
        run4(1'b1, lat);
        n_checks++; if (lat != 87) $display("FAIL avg_latency: got %0d want 87", lat); else n_pass++;
        n_checks++; if (mem4[512] !== 32'h0D0B0503) $display("FAIL avg_word: got %h want 0d0b0503", mem4[512]); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_saturation();
        int lat;
        for (int w = 0; w < 4; w++) begin
            mem4[w] = 32'h10101010;
            mem4[256 + w] = 32'h10101010;
        end
        mem4[512] = 32'h0;
        run4(1'b0, lat);
        n_checks++; if (mem4[512] !== 32'hFFFFFFFF) $display("FAIL sat_max: got %h want ffffffff", mem4[512]); else n_pass++;
        @(negedge clk);
        mem4[512] = 32'h0;
        run4(1'b1, lat);
        n_checks++; if (mem4[512] !== 32'hFFFFFFFF) $display("FAIL sat_avg: got %h want ffffffff", mem4[512]); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int dones;
        int lat;
        load_ident_ramp4();
        @(negedge clk); kick4 = 1'b1; mode4 = 1'b0;
        @(negedge clk); kick4 = 1'b0;
        repeat (29) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (ready4 !== 1'b1) $display("FAIL abort_ready: got %b want 1", ready4); else n_pass++;
        n_checks++; if ({ra4, rb4, wc4} !== 3'b000) $display("FAIL abort_strobes: got %b want 000", {ra4, rb4, wc4}); else n_pass++;
        dones = 0;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            if (done4) dones++;
        end
        n_checks++; if (dones != 0 || wcnt4 != 0) $display("FAIL abort_quiet: got dones=%0d writes=%0d want 0 0", dones, wcnt4); else n_pass++;
        n_checks++; if (mem4[512] !== 32'hDEADBEEF) $display("FAIL abort_mem: got %h want deadbeef", mem4[512]); else n_pass++;
        run4(1'b0, lat);
        n_checks++; if (lat != 87 || mem4[512] !== 32'h100E0806) $display("FAIL abort_rerun: got lat=%0d word=%h want 87 100e0806", lat, mem4[512]); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_kick_held();
        int lat;
        int dones;
        load_ident_ramp4();
        @(negedge clk); kick4 = 1'b1; mode4 = 1'b0;
        lat = -1;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (c == 40) mode4 = 1'b1;
            if (done4) begin lat = c; break; end
        end
        kick4 = 1'b0;
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done4) dones++;
        end
        n_checks++; if (lat != 87) $display("FAIL held_latency: got %0d want 87", lat); else n_pass++;
        n_checks++; if (dones != 0 || wcnt4 != 1) $display("FAIL held_single_job: got dones=%0d writes=%0d want 0 1", dones, wcnt4); else n_pass++;
        n_checks++; if (mem4[512] !== 32'h100E0806) $display("FAIL held_mode_latched: got %h want 100e0806", mem4[512]); else n_pass++;
        n_checks++; if (ready4 !== 1'b1) $display("FAIL held_ready: got %b want 1", ready4); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lat;
        int lat2;
        load_ident_ramp4();
        run4(1'b0, lat);
        kick4 = 1'b1; mode4 = 1'b1;
        @(negedge clk);
        n_checks++; if (ready4 !== 1'b1) $display("FAIL b2b_ready_after_done: got %b want 1", ready4); else n_pass++;
        @(negedge clk);
        kick4 = 1'b0; mode4 = 1'b0;
        n_checks++; if (ready4 !== 1'b0) $display("FAIL b2b_accepted: got ready=%b want 0", ready4); else n_pass++;
        lat2 = -1;
        for (int c = 90; c < 2000; c++) begin
            @(negedge clk);
            if (done4) begin lat2 = c; break; end
        end
        n_checks++; if (lat2 != 176) $display("FAIL b2b_latency: got %0d want 176", lat2); else n_pass++;
        n_checks++; if (mem4[512] !== 32'h0D0B0503 || wcnt4 != 2) $display("FAIL b2b_result: got %h writes=%0d want 0d0b0503 2", mem4[512], wcnt4); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_n8();
        int lat;
        logic [31:0] w;
        for (int i = 0; i < 16; i++) begin
            w = '0;
            for (int k = 0; k < 4; k++)
                if (((4 * i + k) % 9) == 0) w[8*k +: 8] = 8'd1;
            mem8[i] = w;
            mem8[256 + i] = {8'(4 * i + 4), 8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1)};
        end
        for (int i = 0; i < 4; i++) mem8[512 + i] = 32'hDEADBEEF;
        wcnt8 = 0;
        @(negedge clk); kick8 = 1'b1; mode8 = 1'b0;
        @(negedge clk); kick8 = 1'b0; mode8 = 1'b1;
        lat = -1;
        for (int c = 1; c < 3000; c++) begin
            @(negedge clk);
            if (done8) begin lat = c; break; end
        end
        n_checks++; if (lat != 595) $display("FAIL n8_latency: got %0d want 595", lat); else n_pass++;
        n_checks++; if (wcnt8 != 4) $display("FAIL n8_wcount: got %0d want 4", wcnt8); else n_pass++;
        n_checks++; if (mem8[512] !== 32'h100E0C0A) $display("FAIL n8_word0: got %h want 100e0c0a", mem8[512]); else n_pass++;
        n_checks++; if (mem8[513] !== 32'h201E1C1A) $display("FAIL n8_word1: got %h want 201e1c1a", mem8[513]); else n_pass++;
        n_checks++; if (mem8[514] !== 32'h302E2C2A) $display("FAIL n8_word2: got %h want 302e2c2a", mem8[514]); else n_pass++;
        n_checks++; if (mem8[515] !== 32'h403E3C3A) $display("FAIL n8_word3: got %h want 403e3c3a", mem8[515]); else n_pass++;
        n_checks++; if (ovl8 != 0) $display("FAIL n8_overlap: got %0d want 0", ovl8); else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem4[i] = '0;
            mem8[i] = '0;
        end
        test_reset();
        test_max_mode();
        test_avg_mode();
        test_saturation();
        test_reset_abort();
        test_kick_held();
        test_back_to_back();
        test_n8();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
